// File: rtl/arm_control_unit.sv
// arm_control_unit: single-cycle ARM subset decoder with a RUN/MEM_WAIT stall FSM for slow data memory
module arm_control_unit (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         MemReady,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUControl,
  output logic         ALUSrc,
  output logic         MemToReg,
  output logic         RegWrite,
  output logic         PCSrc,
  output logic         MemWrite,
  output logic         MemRead,
  output logic         PCWrite,
  output logic [3:0]   Flags
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state;
  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic n, z, c, v, base, cond_ex;
  logic dp, mem, br, ldr, str, arith, logical, cmp, dp_write, dp_flags;
  logic en, busy, done, upd;
  logic unused_rn;
  assign cond = Instr[31:28];
  assign op = Instr[27:26];
  assign funct = Instr[25:20];
  assign cmd = funct[4:1];
  assign rd = Instr[15:12];
  assign unused_rn = ^Instr[19:16];
  assign {n, z, c, v} = Flags;
  // odd condition codes are the complement of the even code below them; 1110 is AL, 1111 never
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = n == v;
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    cond_ex = (cond == 4'hF) ? 1'b0 : base ^ cond[0];
  end
  assign dp = op == 2'b00;
  assign mem = op == 2'b01;
  assign br = op == 2'b10;
  assign ldr = mem & funct[0];
  assign str = mem & ~funct[0];
  assign cmp = cmd == 4'b1010;
  assign arith = cmd == 4'b0100 || cmd == 4'b0010 || cmp;
  assign logical = cmd == 4'b0000 || cmd == 4'b1100;
  assign dp_write = dp & (arith | logical) & ~cmp;
  assign dp_flags = dp & (cmp | ((arith | logical) & funct[0]));
  assign en = cond_ex & ~Reset;
  // the PC is held while a passed memory access is outstanding, in either state
  assign busy = en & (mem | state == MEM_WAIT);
  assign done = ~busy | MemReady;
  assign upd = en & dp_flags & done;
  assign RegSrc = str ? 2'b10 : br ? 2'b01 : 2'b00;
  assign ImmSrc = mem ? 2'b01 : br ? 2'b10 : 2'b00;
  assign ALUSrc = dp ? funct[5] : 1'b1;
  assign ALUControl = mem ? (funct[3] ? 2'b00 : 2'b01) :
                      ~dp ? 2'b00 :
                      cmd == 4'b0100 ? 2'b00 :
                      cmd == 4'b0000 ? 2'b10 :
                      cmd == 4'b1100 ? 2'b11 : 2'b01;
  assign MemToReg = ldr;
  assign RegWrite = en & (dp_write | ldr) & done;
  assign MemWrite = en & str;
  assign MemRead = en & ldr;
  assign PCSrc = en & done & (br | (rd == 4'hF & (dp_write | ldr)));
  assign PCWrite = Reset | done;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      Flags <= 4'b0000;
    end else begin
      state <= (busy & ~MemReady) ? MEM_WAIT : RUN;
      if (upd) begin
        Flags[3:2] <= ALUFlags[3:2];
        if (arith) Flags[1:0] <= ALUFlags[1:0];
      end
    end
  end
endmodule

// File: tb/tb_arm_control_unit.sv
// tb_arm_control_unit: directed scenarios plus random instruction stream against a mnemonic-level reference model
module tb_arm_control_unit;
  logic Clk = 0, Reset = 1, MemReady = 1, ALUSrc, MemToReg, RegWrite, PCSrc, MemWrite, MemRead, PCWrite;
  logic [31:12] Instr = '0;
  logic [3:0] ALUFlags = '0, Flags;
  logic [1:0] RegSrc, ImmSrc, ALUControl;
  int errors = 0, checks = 0;
  logic [3:0] mflags = 4'b0000;
  bit mwait = 0;

  arm_control_unit dut (.Clk(Clk), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .PCSrc(PCSrc), .MemWrite(MemWrite), .MemRead(MemRead), .PCWrite(PCWrite), .Flags(Flags));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] cnd, input logic [1:0] o, input logic [5:0] f, input logic [3:0] d);
    return {cnd, o, f, 4'h0, d};
  endfunction

  function automatic bit passes(input logic [3:0] cnd, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cnd)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return z || n != v;
      4'hE: return 1;
      default: return 0;
    endcase
  endfunction

  // one clock: drive, check combinational outputs against the model, clock, check Flags
  task automatic step(input logic [19:0] ins, input logic [3:0] af, input bit rdy, input bit rst);
    bit go, is_dp, is_mem, is_br, ld, st, s, cmpi, add_sub, and_orr, known, writes, stall, fin;
    logic [3:0] cmd, nf;
    logic [1:0] ac;
    Instr = ins; ALUFlags = af; MemReady = rdy; Reset = rst;
    #2;
    cmd = ins[12:9];
    is_dp = ins[15:14] == 0; is_mem = ins[15:14] == 1; is_br = ins[15:14] == 2;
    ld = is_mem && ins[8]; st = is_mem && !ins[8];
    s = ins[8];
    cmpi = cmd == 4'b1010;
    add_sub = cmd == 4'b0100 || cmd == 4'b0010;
    and_orr = cmd == 4'b0000 || cmd == 4'b1100;
    known = add_sub || and_orr || cmpi;
    go = !rst && passes(ins[19:16], mflags);
    writes = (is_dp && (add_sub || and_orr)) || ld;
    stall = go && (is_mem || mwait) && !rdy;
    fin = go && !stall;
    nf = mflags;
    if (rst) begin
      chk("rst_regwrite", {3'b0, RegWrite}, 0); chk("rst_memwrite", {3'b0, MemWrite}, 0);
      chk("rst_memread", {3'b0, MemRead}, 0); chk("rst_pcsrc", {3'b0, PCSrc}, 0);
      chk("rst_pcwrite", {3'b0, PCWrite}, 1);
      nf = 0;
    end else begin
      chk("regwrite", {3'b0, RegWrite}, {3'b0, fin && writes});
      chk("memwrite", {3'b0, MemWrite}, {3'b0, go && st});
      chk("memread", {3'b0, MemRead}, {3'b0, go && ld});
      chk("pcsrc", {3'b0, PCSrc}, {3'b0, fin && (is_br || (ins[3:0] == 4'hF && writes))});
      chk("pcwrite", {3'b0, PCWrite}, {3'b0, !stall});
      if (is_dp) begin
        chk("dp_regsrc", {2'b0, RegSrc}, 0); chk("dp_immsrc", {2'b0, ImmSrc}, 0);
        chk("dp_alusrc", {3'b0, ALUSrc}, {3'b0, ins[13]});
        if (known) begin
          ac = cmd == 4'b0100 ? 2'd0 : cmd == 4'b0000 ? 2'd2 : cmd == 4'b1100 ? 2'd3 : 2'd1;
          chk("dp_aluctl", {2'b0, ALUControl}, {2'b0, ac});
        end
        if (go && known && (s || cmpi)) nf = {af[3:2], and_orr ? mflags[1:0] : af[1:0]};
      end
      if (is_mem) begin
        chk("mem_immsrc", {2'b0, ImmSrc}, 1); chk("mem_alusrc", {3'b0, ALUSrc}, 1);
        chk("mem_aluctl", {2'b0, ALUControl}, ins[11] ? 0 : 1);
        chk("mem_regsrc", {2'b0, RegSrc}, ld ? 0 : 2);
        if (ld) chk("ldr_memtoreg", {3'b0, MemToReg}, 1);
      end
      if (is_br) begin
        chk("br_regsrc", {2'b0, RegSrc}, 1); chk("br_immsrc", {2'b0, ImmSrc}, 2);
        chk("br_alusrc", {3'b0, ALUSrc}, 1); chk("br_aluctl", {2'b0, ALUControl}, 0);
      end
    end
    @(posedge Clk);
    #1;
    mflags = nf;
    mwait = stall;
    chk("flags", Flags, mflags);
  endtask

  initial begin
    logic [19:0] ins, addr15, ldr15, ldr, str, orrs;
    logic [3:0] cmds [6];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0110};
    ldr = mk(4'hE, 2'b01, 6'b011001, 4'h3);
    str = mk(4'hE, 2'b01, 6'b010000, 4'h3);
    orrs = mk(4'hE, 2'b00, 6'b011001, 4'h2);
    step(ldr, 0, 0, 1);
    step(ldr, 0, 0, 1);
    chk("reset_flags", Flags, 4'b0000);
    step(mk(4'hE, 2'b00, 6'b101001, 4'h1), 4'b0100, 1, 0);
    chk("adds_flags", Flags, 4'b0100);
    step(mk(4'h0, 2'b10, 6'b000000, 4'h0), 0, 1, 0);
    step(mk(4'hE, 2'b00, 6'b101001, 4'h1), 4'b0000, 1, 0);
    step(mk(4'h0, 2'b10, 6'b000000, 4'h0), 0, 1, 0);
    step(mk(4'hE, 2'b00, 6'b101001, 4'h1), 4'b0011, 1, 0);
    step(orrs, 4'b1011, 1, 0);
    chk("orrs_flags", Flags, 4'b1011);
    step(orrs, 4'b0100, 1, 0);
    chk("orrs_keep_cv", Flags, 4'b0111);
    for (int i = 0; i < 3; i++) step(ldr, 0, 0, 0);
    step(ldr, 0, 1, 0);
    step(mk(4'hE, 2'b00, 6'b001000, 4'h1), 0, 0, 0);
    step(str, 0, 0, 0);
    step(str, 0, 0, 0);
    step(str, 0, 0, 1);
    chk("wait_reset_flags", Flags, 4'b0000);
    step(mk(4'hE, 2'b00, 6'b001000, 4'h1), 0, 0, 0);
    addr15 = mk(4'hE, 2'b00, 6'b001000, 4'hF);
    step(addr15, 0, 0, 0);
    step(mk(4'hF, 2'b00, 6'b001000, 4'hF), 0, 0, 0);
    ldr15 = mk(4'hE, 2'b01, 6'b011001, 4'hF);
    step(ldr15, 0, 0, 0);
    step(ldr15, 0, 0, 0);
    step(ldr15, 0, 1, 0);
    ins = ldr;
    for (int i = 0; i < 500; i++) begin
      if (!mwait) begin
        ins = {$urandom} [19:0];
        if (ins[15:14] == 0) ins[12:9] = cmds[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
        if ($urandom_range(0, 2) == 0) ins[19:16] = 4'hE;
      end
      step(ins, 4'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arm_control_unit.md
ARM_CONTROL_UNIT -- requirements
Module: arm_control_unit

Interface
REQ-001 The block SHALL be clocked by `Clk` (1-bit input, single clock, rising edge).
REQ-002 The block SHALL take `Reset` (1-bit input), synchronous and active-high.
REQ-003 The block SHALL take `Instr`, input, [31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
REQ-004 The block SHALL take `ALUFlags`, input, [3:0]: NZCV from the datapath ALU in the current cycle.
REQ-005 The block SHALL take `MemReady`, input, 1 bit: data memory has completed the current access.
REQ-006 The block SHALL drive the following datapath control outputs: `RegSrc`[1:0], `ImmSrc`[1:0], `ALUControl`[1:0], `ALUSrc`, `MemToReg`, `RegWrite`, `PCSrc`.
REQ-007 The block SHALL drive `MemWrite` and `MemRead` (1 bit each): data memory strobes.
REQ-008 The block SHALL drive `PCWrite` (1 bit): PC register load enable; 0 holds the PC.
REQ-009 The block SHALL drive `Flags`, output, [3:0]: architectural NZCV register.

Function
REQ-010 Data-processing decode (op=00) SHALL be:
- RegSrc=00, ImmSrc=00, ALUSrc=funct[5].
- cmd funct[4:1]: 0100 ADD -> ALUControl=00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11; 1010 CMP -> 01 with no register write.
- Any other cmd SHALL suppress RegWrite, MemWrite and flag update.
REQ-011 Memory decode (op=01) SHALL be:
- ImmSrc=01, ALUSrc=1.
- ALUControl=00 if funct[3]=1, else 01.
- LDR (funct[0]=1): RegSrc=00, MemToReg=1, MemRead=1.
- STR (funct[0]=0): RegSrc=10, MemWrite=1, no register write.
REQ-012 Branch decode (op=10) SHALL be: RegSrc=01, ImmSrc=10, ALUSrc=1, ALUControl=00, no register or memory write. op=11 SHALL be a no-op.
REQ-013 CondEx SHALL be evaluated combinationally from cond and the registered `Flags` using the full ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. cond=1111 SHALL give CondEx=0.
REQ-014 When CondEx=0: RegWrite, MemWrite, MemRead and PCSrc SHALL be 0, flags SHALL NOT update, and PCWrite SHALL be 1.
REQ-015 PCSrc SHALL be CondEx & (branch | (Rd==4'hF & decoded register write)).
REQ-016 Flag update rules:
- Flag update SHALL occur only for data-processing with funct[0]=1 (or CMP) and CondEx=1.
- ADD/SUB/CMP SHALL load all of NZCV.
- AND/ORR SHALL load NZ only; CV SHALL be retained.
REQ-017 FSM states SHALL be RUN and MEM_WAIT.
REQ-018 In RUN, a non-memory or condition-failed instruction SHALL complete in 1 cycle with PCWrite=1.
REQ-019 In RUN, a condition-passed LDR/STR with MemReady=1 SHALL complete in the same cycle:
- PCWrite=1.
- RegWrite=1 for LDR.
- State SHALL stay RUN.
REQ-020 In RUN, a condition-passed LDR/STR with MemReady=0 SHALL:
- Force PCWrite=0 and RegWrite=0.
- Hold MemRead/MemWrite asserted.
- Go to MEM_WAIT next cycle.
REQ-021 In MEM_WAIT, all decoded controls SHALL be held stable (Instr is held by the held PC).
- While MemReady=0: PCWrite=0, RegWrite=0.
- First cycle with MemReady=1: commit (PCWrite=1, RegWrite=1 if LDR) and return to RUN next cycle.
REQ-022 An LDR with Rd=15 SHALL assert PCSrc only in the commit cycle.
REQ-023 There SHALL be no limit on wait length; the FSM SHALL NOT time out.

Reset
REQ-024 On `Reset`=1 at a rising edge: state<=RUN, Flags<=4'b0000, regardless of the current state, including MEM_WAIT.
REQ-025 While `Reset`=1: RegWrite, MemWrite, MemRead, PCSrc SHALL be 0 and PCWrite SHALL be 1; all other outputs SHALL be don't-care.

Verification
REQ-026 Reset released; ADDS (Instr[31:20]=0xE29) with ALUFlags=0100 -> RegWrite=1, ALUControl=00, ALUSrc=1; next cycle Flags=0100.
REQ-027 Flags=0100; BEQ (cond=0000, op=10) -> PCSrc=1, ImmSrc=10; Flags=0000 with the same BEQ -> PCSrc=0, PCWrite=1.
REQ-028 ORRS with ALUFlags=1011 while Flags=0011 -> next Flags=1011 (CV retained from old value 11).
REQ-029 LDR with MemReady=0 for 3 cycles, then 1 -> PCWrite=0, RegWrite=0 for 3 cycles, MemRead=1 throughout; commit cycle PCWrite=1, RegWrite=1, MemToReg=1; state RUN afterwards.
REQ-030 STR in MEM_WAIT with Reset=1 -> next cycle state RUN, Flags=0000, MemWrite=0.
REQ-031 ADD with Rd=15, cond=AL -> PCSrc=1, RegWrite=1; same instruction with cond=1111 -> all writes 0, PCWrite=1.
